// File: rtl/rv32e_fetch_queue.sv
// rv32e_fetch_queue: instruction prefetch FIFO between an async-read program
// ROM and the decode stage. Fetches one word per cycle at fetch_pc, tags each
// entry with its PC, and flushes/restarts on a redirect from execute.
//
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   program_addr_bus   - ROM word address (always fetch_pc)
//   program_data_bus   - ROM read data, combinational from the address
//   inst_valid/data/pc - head entry presented to decode
//   inst_ready         - decode accepts the head entry this cycle
//   redirect_valid/pc  - flush the queue and restart fetch at redirect_pc
//   queue_count        - number of valid entries (debug)
module rv32e_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              program_addr_bus,
    input  logic [31:0]              program_data_bus,
    output logic                     inst_valid,
    output logic [31:0]              inst_data,
    output logic [31:0]              inst_pc,
    input  logic                     inst_ready,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        fetch_pc;
    logic               pop_c;
    logic               push_c;

    // Handshake qualifiers; a full queue may still push when the head pops.
    always_comb begin
        pop_c  = (count != '0) && inst_ready;
        push_c = !redirect_valid && ((count < CNT_W'(DEPTH)) || pop_c);
    end

    // Queue state; redirect overrides push and discards any same-cycle pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= '{pc: fetch_pc, data: program_data_bus};
                wr_ptr      <= wr_ptr + PTR_W'(1);
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Outputs are decoded from state only; nothing depends on inst_ready.
    always_comb begin
        program_addr_bus = fetch_pc;
        inst_valid       = (count != '0);
        inst_data        = mem[rd_ptr].data;
        inst_pc          = mem[rd_ptr].pc;
        queue_count      = count;
    end

endmodule

// File: tb/tb_rv32e_fetch_queue.sv
// Directed, table-driven bench for rv32e_fetch_queue plus hand sequences for
// asynchronous reset and PC wrap-around (second instance, RESET_PC near top).
module tb_rv32e_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr, rdata;
    logic        valid, ready = 1'b0, rv = 1'b0;
    logic [31:0] idata, ipc, rpc = 32'h0;
    logic [2:0]  cnt;

    logic        reset2 = 1'b0;
    logic [31:0] addr2, rdata2;
    logic        valid2;
    logic [31:0] idata2, ipc2;
    logic [2:0]  cnt2;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // ROM contents: word index plus 0x1000_0000.
    function automatic logic [31:0] romv(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign rdata  = romv(addr);
    assign rdata2 = romv(addr2);

    rv32e_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .program_addr_bus(addr), .program_data_bus(rdata),
        .inst_valid(valid), .inst_data(idata), .inst_pc(ipc),
        .inst_ready(ready), .redirect_valid(rv), .redirect_pc(rpc),
        .queue_count(cnt)
    );

    rv32e_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .reset(reset2),
        .program_addr_bus(addr2), .program_data_bus(rdata2),
        .inst_valid(valid2), .inst_data(idata2), .inst_pc(ipc2),
        .inst_ready(1'b1), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .queue_count(cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic        chk_head;
        logic [31:0] epc;
        logic [2:0]  ecnt;
        logic [31:0] eaddr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] p,
                                input logic e, input logic h, input logic [31:0] hp,
                                input logic [2:0] c, input logic [31:0] a);
        vec_t x;
        x.ready = r; x.rv = v; x.rpc = p; x.ev = e; x.chk_head = h;
        x.epc = hp; x.ecnt = c; x.eaddr = a;
        return x;
    endfunction

    vec_t vq[$];

    initial begin
        // ready, redirect, redirect_pc, exp valid, check head, exp head pc, exp count, exp addr
        vq.push_back(mk(1, 0, 0,      1, 1, 32'h000, 1, 32'h004)); // first push
        vq.push_back(mk(1, 0, 0,      1, 1, 32'h004, 1, 32'h008)); // streaming
        vq.push_back(mk(1, 0, 0,      1, 1, 32'h008, 1, 32'h00C));
        vq.push_back(mk(0, 1, 0,      0, 0, 32'h000, 0, 32'h000)); // redirect to 0
        vq.push_back(mk(0, 0, 0,      1, 1, 32'h000, 1, 32'h004)); // stall: fill
        vq.push_back(mk(0, 0, 0,      1, 1, 32'h000, 2, 32'h008));
        vq.push_back(mk(0, 0, 0,      1, 1, 32'h000, 3, 32'h00C));
        vq.push_back(mk(0, 0, 0,      1, 1, 32'h000, 4, 32'h010)); // full
        for (int i = 0; i < 6; i++)
            vq.push_back(mk(0, 0, 0,  1, 1, 32'h000, 4, 32'h010)); // frozen
        vq.push_back(mk(1, 0, 0,      1, 1, 32'h004, 4, 32'h014)); // push+pop when full
        vq.push_back(mk(0, 0, 0,      1, 1, 32'h004, 4, 32'h014));
        vq.push_back(mk(1, 0, 0,      1, 1, 32'h008, 4, 32'h018)); // drain in order
        vq.push_back(mk(1, 0, 0,      1, 1, 32'h00C, 4, 32'h01C));
        vq.push_back(mk(1, 0, 0,      1, 1, 32'h010, 4, 32'h020));
        vq.push_back(mk(0, 1, 32'h103, 0, 0, 32'h000, 0, 32'h100)); // redirect, low bits dropped
        vq.push_back(mk(0, 0, 0,      1, 1, 32'h100, 1, 32'h104));
        vq.push_back(mk(1, 1, 32'h208, 0, 0, 32'h000, 0, 32'h208)); // redirect + pop
        vq.push_back(mk(1, 0, 0,      1, 1, 32'h208, 1, 32'h20C));
        vq.push_back(mk(1, 0, 0,      1, 1, 32'h20C, 1, 32'h210));
        vq.push_back(mk(0, 0, 0,      1, 1, 32'h20C, 2, 32'h214));
        vq.push_back(mk(0, 0, 0,      1, 1, 32'h20C, 3, 32'h218)); // 3 entries held

        #1 reset = 1'b1; reset2 = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_count", 32'(cnt), 32'h0);
        chk("rst_addr",  addr,  32'h0);
        chk("rst_data",  idata, 32'h0);
        chk("rst_pc",    ipc,   32'h0);
        chk("rst2_addr", addr2, 32'hFFFF_FFF8);
        reset = 1'b0;

        foreach (vq[i]) begin
            ready = vq[i].ready; rv = vq[i].rv; rpc = vq[i].rpc;
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vq[i].ev));
            chk($sformatf("v%0d_count", i), 32'(cnt), 32'(vq[i].ecnt));
            chk($sformatf("v%0d_addr", i), addr, vq[i].eaddr);
            if (vq[i].chk_head) begin
                chk($sformatf("v%0d_pc", i), ipc, vq[i].epc);
                chk($sformatf("v%0d_data", i), idata, romv(vq[i].epc));
            end
        end
        ready = 1'b0; rv = 1'b0;

        // Asynchronous reset between edges with 3 entries held.
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(valid), 32'h0);
        chk("arst_count", 32'(cnt), 32'h0);
        chk("arst_addr",  addr, 32'h0);
        @(negedge clk);
        reset = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        chk("arst_restart_count", 32'(cnt), 32'h1);
        chk("arst_restart_pc",    ipc, 32'h0);
        chk("arst_restart_data",  idata, 32'h1000_0000);

        // PC wrap on the second instance.
        @(negedge clk);
        reset2 = 1'b0;
        begin
            logic [31:0] wpc [4];
            logic [31:0] wdat [4];
            wpc[0] = 32'hFFFF_FFF8; wdat[0] = 32'h4FFF_FFFE;
            wpc[1] = 32'hFFFF_FFFC; wdat[1] = 32'h4FFF_FFFF;
            wpc[2] = 32'h0000_0000; wdat[2] = 32'h1000_0000;
            wpc[3] = 32'h0000_0004; wdat[3] = 32'h1000_0001;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                chk($sformatf("wrap%0d_valid", k), 32'(valid2), 32'h1);
                chk($sformatf("wrap%0d_pc", k), ipc2, wpc[k]);
                chk($sformatf("wrap%0d_data", k), idata2, wdat[k]);
                chk($sformatf("wrap%0d_addr", k), addr2, wpc[k] + 32'd4);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32e_fetch_queue.md
# rv32e_fetch_queue

Instruction prefetch queue between the asynchronous-read program ROM and the rv32e core's decode stage. It drives the ROM address bus from its own fetch PC and captures one instruction word per cycle into a small FIFO. Each entry is tagged with its PC. Decode pops entries through a valid/ready handshake, and a redirect from execute (branch/jump) flushes the queue and restarts fetch.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- program_addr_bus  output  32  ROM word address, always equal to fetch_pc.
- program_data_bus  input  32  ROM read data, combinational from program_addr_bus, valid in the same cycle.
- inst_valid  output  1  head entry present (count != 0).
- inst_data  output  32  instruction word at the head.
- inst_pc  output  32  PC of the head entry.
- inst_ready  input  1  decode accepts the head entry this cycle.
- redirect_valid  input  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
- queue_count  output  $clog2(DEPTH)+1  number of valid entries, for debug and verification.

## Operation
- State: fetch_pc (32 bits), circular buffer of DEPTH {pc, data} pairs, read pointer, write pointer, count.
- pop = inst_valid & inst_ready.
- push = !redirect_valid & (count < DEPTH | pop). Simultaneous push and pop when full is legal; count stays at DEPTH.
- On push:
  - Write {fetch_pc, program_data_bus} at the write pointer.
  - Advance the write pointer modulo DEPTH.
  - fetch_pc <= fetch_pc + 4. Arithmetic is 32-bit unsigned and wraps: 32'hFFFF_FFFC -> 32'h0.
- On pop: advance the read pointer modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when both or neither occur.
- Redirect has priority over everything else in its cycle:
  - count <= 0; read and write pointers reset to 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No push. A pop in the same cycle is allowed and completes, but the queue is flushed regardless.
- Full: no push, and fetch_pc holds. program_addr_bus stays stable until space frees.
- Empty: inst_valid = 0. inst_data and inst_pc are don't-care, but must not be X after reset.
- Entries leave in strict program (PC) order. No entry is duplicated or skipped between redirects.

## Timing
- Reset (asynchronous assert) values:
  - fetch_pc = RESET_PC, so program_addr_bus = RESET_PC.
  - count = 0, queue_count = 0, inst_valid = 0.
  - inst_data = 0, inst_pc = 0; storage is cleared.
- Reset deassertion is synchronous to clk as seen by the block. The first push happens on the first rising edge with reset low.
- Fetch-to-decode latency: 1 cycle. A word fetched at edge N is visible at inst_* after edge N, so inst_valid rises 1 cycle after reset release.
- Redirect-to-first-new-instruction: 2 edges. The redirect edge loads fetch_pc; the next edge pushes; inst_valid is high after that edge.
- Throughput: 1 instruction per cycle sustained while inst_ready is held high.
- inst_valid, inst_data, inst_pc and queue_count are registered-state outputs with no combinational path from inst_ready.
- program_addr_bus is purely fetch_pc.
- Reset asserted mid-operation: the queue empties immediately and fetch restarts at RESET_PC. Pending entries are lost.

## Test plan
- Reset release, ROM[i] = 32'h1000_0000 + i, inst_ready = 1 -> inst_valid high 1 cycle after release; (inst_pc, inst_data) = (0, 32'h1000_0000), (4, 32'h1000_0001), ... on consecutive cycles.
- inst_ready held 0 for 10 cycles with DEPTH = 4 -> queue_count saturates at 4, program_addr_bus frozen at 16. On release, PCs 0, 4, 8, 12, 16 pop in order with no gap.
- Full queue with inst_ready = 1 for 1 cycle -> push and pop in the same edge; queue_count stays 4; next head PC = 4.
- With the queue holding PCs 8..20, redirect_valid = 1 with redirect_pc = 32'h0000_0103 -> next edge: queue_count = 0, program_addr_bus = 32'h100; two edges later: inst_pc = 32'h100.
- RESET_PC = 32'hFFFF_FFF8 -> popped PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset asserted asynchronously mid-cycle while the queue holds 3 entries -> inst_valid and queue_count go to 0 and program_addr_bus goes to RESET_PC without waiting for a clk edge.
